// File: rtl/ex_div_seq_if.sv
// ex_div_seq_if: issue/result handshake bundle for the EX-stage divide sequencer.
//   in_*  : operation offered by ID (valid/ready), opcode, operands, destination
//   out_* : result handed to the EX->ME path (valid/ready), result value, destination
//   busy  : sequencer occupied, used by EX to stall ID
// master = the EX pipeline side driving operations; slave = the divider.
interface ex_div_seq_if #(
  parameter int unsigned DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_op;
  logic [DATA_W-1:0] in_src1;
  logic [DATA_W-1:0] in_src2;
  logic [4:0]        in_dest;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic [4:0]        out_dest;
  logic              busy;

  modport master (
    output in_valid, in_op, in_src1, in_src2, in_dest, out_ready,
    input  in_ready, out_valid, out_result, out_dest, busy
  );

  modport slave (
    input  in_valid, in_op, in_src1, in_src2, in_dest, out_ready,
    output in_ready, out_valid, out_result, out_dest, busy
  );
endinterface

// File: rtl/ex_div_seq.sv
// ex_div_seq: iterative radix-2 restoring divider for div.w / mod.w / div.wu / mod.wu.
//   clk    : clock, all state on rising edge
//   resetn : asynchronous active-low reset
//   flush  : synchronous cancel, drops any operation or held result
//   dif    : slave side of ex_div_seq_if (issue handshake, result handshake, busy)
// One quotient bit per cycle; 33-cycle latency, 1 cycle for divide by zero.
module ex_div_seq #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 5
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  ex_div_seq_if.slave dif
);

  localparam int unsigned DEST_W = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   quo_q, quo_d;
  logic [DATA_W-1:0]   dvs_q, dvs_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [DEST_W-1:0]   dest_q, dest_d;
  logic                is_mod_q, is_mod_d;
  logic                neg_quo_q, neg_quo_d;
  logic                neg_rem_q, neg_rem_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;

  logic                signed_op;
  logic [DATA_W-1:0]   src1_mag;
  logic [DATA_W-1:0]   src2_mag;
  logic [DATA_W:0]     shifted;
  logic [DATA_W:0]     diff;

  // Operand magnitudes and one restoring-divide trial step.
  // rem < divisor always holds, so the shifted value fits in DATA_W+1 bits and
  // the top bit of the difference is a reliable borrow flag.
  always_comb begin
    signed_op = ~dif.in_op[1];
    src1_mag  = (signed_op && dif.in_src1[DATA_W-1]) ? DATA_W'(-dif.in_src1) : dif.in_src1;
    src2_mag  = (signed_op && dif.in_src2[DATA_W-1]) ? DATA_W'(-dif.in_src2) : dif.in_src2;
    shifted   = {rem_q, quo_q[DATA_W-1]};
    diff      = shifted - {1'b0, dvs_q};
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    result_d  = result_q;
    dest_d    = dest_q;
    is_mod_d  = is_mod_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;

    unique case (state_q)
      S_IDLE: begin
        if (dif.in_valid && !flush) begin
          is_mod_d  = dif.in_op[0];
          dest_d    = dif.in_dest;
          neg_quo_d = signed_op & (dif.in_src1[DATA_W-1] ^ dif.in_src2[DATA_W-1]);
          neg_rem_d = signed_op & dif.in_src1[DATA_W-1];
          quo_d     = src1_mag;
          dvs_d     = src2_mag;
          rem_d     = '0;
          cnt_d     = '0;
          if (dif.in_src2 == '0) begin
            // Divide by zero: all-ones quotient, dividend passed through as remainder.
            result_d = dif.in_op[0] ? dif.in_src1 : '1;
            state_d  = S_DONE;
          end else begin
            state_d  = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (!diff[DATA_W]) begin
          rem_d = diff[DATA_W-1:0];
          quo_d = {quo_q[DATA_W-2:0], 1'b1};
        end else begin
          rem_d = shifted[DATA_W-1:0];
          quo_d = {quo_q[DATA_W-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == {CNT_W{1'b1}}) begin
          // Sign fix-up folded into the final iteration.
          if (is_mod_q) result_d = neg_rem_q ? DATA_W'(-rem_d) : rem_d;
          else          result_d = neg_quo_q ? DATA_W'(-quo_d) : quo_d;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (dif.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end

    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      result_q    <= '0;
      dest_q      <= '0;
      is_mod_q    <= 1'b0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      result_q    <= result_d;
      dest_q      <= dest_d;
      is_mod_q    <= is_mod_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign dif.in_ready   = in_ready_q;
  assign dif.out_valid  = out_valid_q;
  assign dif.busy       = busy_q;
  assign dif.out_result = result_q;
  assign dif.out_dest   = dest_q;

endmodule
